// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer around a 16-point FFT pipeline: serial load into a parallel input bank,
// wait out the pipeline latency, capture the results and stream them out with valid/ready.
`timescale 1ns/1ps
module fft16_frame_ctrl #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FFT_LAT    = 4,
    parameter int unsigned BITREV_OUT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [DATA_W-1:0]    i_in_real,
    input  logic [DATA_W-1:0]    i_in_imag,
    output logic [16*DATA_W-1:0] o_fft_real_in,
    output logic [16*DATA_W-1:0] o_fft_imag_in,
    input  logic [16*DATA_W-1:0] i_fft_real_out,
    input  logic [16*DATA_W-1:0] i_fft_imag_out,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [DATA_W-1:0]    o_out_real,
    output logic [DATA_W-1:0]    o_out_imag,
    output logic [3:0]           o_out_index,
    output logic                 o_out_last,
    output logic                 o_busy,
    output logic [15:0]          o_frame_cnt
);

    localparam int unsigned WAIT_W = $clog2(FFT_LAT + 2);

    typedef enum logic [1:0] {StLoad, StWait, StDrain} state_t;

    state_t                  r_state, w_state_next;
    logic [4:0]              r_in_cnt, w_in_cnt_next, w_in_cnt_acc;
    logic [3:0]              r_out_k, w_out_k_next, w_rd_slot;
    logic [WAIT_W-1:0]       r_wait_cnt, w_wait_next;
    logic [15:0]             r_frame_cnt, w_frame_next;
    logic [15:0][DATA_W-1:0] r_in_real, r_in_imag, r_out_real, r_out_imag;
    logic                    w_accept, w_handshake, w_capture;

    assign o_in_ready   = (r_in_cnt < 5'd16) && (r_state != StWait);
    assign w_accept     = i_in_valid && o_in_ready;
    assign o_out_valid  = (r_state == StDrain);
    assign w_handshake  = o_out_valid && i_out_ready;
    assign w_in_cnt_acc = r_in_cnt + {4'd0, w_accept};

    always_comb begin
        w_state_next  = r_state;
        w_in_cnt_next = w_in_cnt_acc;
        w_out_k_next  = r_out_k;
        w_wait_next   = r_wait_cnt;
        w_frame_next  = r_frame_cnt;
        w_capture     = 1'b0;
        unique case (r_state)
            StLoad: begin
                if (w_in_cnt_acc == 5'd16) begin
                    w_state_next = StWait;
                    w_wait_next  = '0;
                end
            end
            StWait: begin
                w_wait_next = r_wait_cnt + WAIT_W'(1);
                if (r_wait_cnt == WAIT_W'(FFT_LAT)) begin
                    w_capture     = 1'b1;
                    w_in_cnt_next = 5'd0;
                    w_out_k_next  = 4'd0;
                    w_wait_next   = '0;
                    w_state_next  = StDrain;
                end
            end
            StDrain: begin
                if (w_handshake) begin
                    w_out_k_next = r_out_k + 4'd1;
                    if (o_out_last) begin
                        w_frame_next = r_frame_cnt + 16'd1;
                        // A frame that filled up during the drain goes straight to the pipeline.
                        if (w_in_cnt_acc == 5'd16) begin
                            w_state_next = StWait;
                            w_wait_next  = '0;
                        end else begin
                            w_state_next = StLoad;
                        end
                    end
                end
            end
            default: w_state_next = StLoad;
        endcase
        if (i_flush) begin
            w_state_next  = StLoad;
            w_in_cnt_next = 5'd0;
            w_out_k_next  = 4'd0;
            w_wait_next   = '0;
            w_frame_next  = r_frame_cnt;
            w_capture     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StLoad;
            r_in_cnt    <= 5'd0;
            r_out_k     <= 4'd0;
            r_wait_cnt  <= '0;
            r_frame_cnt <= 16'd0;
            r_in_real   <= '0;
            r_in_imag   <= '0;
            r_out_real  <= '0;
            r_out_imag  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_in_cnt    <= w_in_cnt_next;
            r_out_k     <= w_out_k_next;
            r_wait_cnt  <= w_wait_next;
            r_frame_cnt <= w_frame_next;
            if (w_accept && !i_flush) begin
                r_in_real[r_in_cnt[3:0]] <= i_in_real;
                r_in_imag[r_in_cnt[3:0]] <= i_in_imag;
            end
            if (w_capture) begin
                r_out_real <= i_fft_real_out;
                r_out_imag <= i_fft_imag_out;
            end
        end
    end

    assign w_rd_slot = (BITREV_OUT != 0) ? {r_out_k[0], r_out_k[1], r_out_k[2], r_out_k[3]}
                                         : r_out_k;

    assign o_fft_real_in = r_in_real;
    assign o_fft_imag_in = r_in_imag;
    assign o_out_real    = r_out_real[w_rd_slot];
    assign o_out_imag    = r_out_imag[w_rd_slot];
    assign o_out_index   = r_out_k;
    assign o_out_last    = o_out_valid && (r_out_k == 4'hF);
    assign o_busy        = (r_state != StLoad) || (r_in_cnt != 5'd0);
    assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: doc/fft16_frame_ctrl.md
Name: fft16_frame_ctrl

Overview:
- Streaming sequencer for the 16-point radix-2 FFT pipeline (four registered stages, 16-bit signed complex I/O).
- Collects 16 serial complex samples into an input register bank that drives the FFT's parallel inputs, then waits out the pipeline latency.
- Captures the 16 parallel results into an output bank and streams them out serially with a valid/ready handshake.
- Loading of the next frame overlaps draining of the current one.

Parameters:
- DATA_W, 16: width of each real and each imaginary sample.
- FFT_LAT, 4: register latency of the FFT pipeline, in cycles.
- BITREV_OUT, 1: 1 = output beat k reads capture slot bitrev4(k); 0 = reads slot k.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous abort: discard partial input and output frames.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller can accept an input sample.
- in_real  in  DATA_W  input sample, real part (signed).
- in_imag  in  DATA_W  input sample, imaginary part (signed).
- fft_real_in  out  16*DATA_W  to FFT real_in0..15; slot n at bits [n*DATA_W +: DATA_W].
- fft_imag_in  out  16*DATA_W  to FFT imag_in0..15; same packing.
- fft_real_out  in  16*DATA_W  from FFT real_out0..15; same packing.
- fft_imag_out  in  16*DATA_W  from FFT imag_out0..15; same packing.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_real  out  DATA_W  output beat, real part.
- out_imag  out  DATA_W  output beat, imaginary part.
- out_index  out  4  frequency bin k of the current beat.
- out_last  out  1  high on the beat with k==15.
- busy  out  1  state != LOAD or in_cnt != 0.
- frame_cnt  out  16  completed output frames; wraps from 0xFFFF to 0.

Behaviour:
- Reset (async, rst=1): state=LOAD, in_cnt=0, out_k=0, wait_cnt=0, frame_cnt=0, both register banks 0, out_valid=0, in_ready=1, out_last=0, busy=0.
- Input side:
  - in_ready = (in_cnt < 16) and (state != WAIT).
  - An accept (in_valid & in_ready) writes bank slot in_cnt and increments in_cnt (0..16).
  - fft_*_in are driven directly from the input bank; the bank holds stable through WAIT.
- State LOAD: when in_cnt reaches 16 (including on the accepting edge), go to WAIT with wait_cnt=0.
- State WAIT:
  - wait_cnt increments each cycle.
  - On the edge where wait_cnt==FFT_LAT, capture fft_*_out into the output bank, set in_cnt=0, out_k=0, and go to DRAIN.
  - Last input accept to first out_valid = FFT_LAT+2 cycles (6 at default).
- State DRAIN:
  - out_valid=1. out_real/out_imag come from output bank slot (BITREV_OUT ? bitrev4(out_k) : out_k). out_index=out_k, out_last=(out_k==15).
  - Outputs hold stable while out_ready=0.
  - On a handshake, out_k increments. On the out_last handshake, frame_cnt increments, then:
    - next state is WAIT (wait_cnt=0) if in_cnt==16 after this edge, including a 16th sample accepted on the same edge;
    - otherwise next state is LOAD, keeping in_cnt.
- Overlap: the input bank refills during DRAIN. When full, in_ready=0 until the drain completes. Full bank plus stalled drain is backpressure, with no data loss.
- flush (synchronous):
  - state=LOAD, in_cnt=0, out_k=0, out_valid=0; frame_cnt is unchanged.
  - Banks are not cleared.
  - An input accept or output handshake on the flush edge is discarded. flush overrides all other events.
- rst mid-frame: immediate return to reset values; no partial output is emitted.
- No arithmetic on data; samples pass bit-exact. Scaling is owned by the FFT stages.

Test Plan:
- Impulse: x[0]=(256,0), others 0, out_ready=1 -> 16 beats of (256·g,0), g = FFT scaling; out_index 0..15; out_last on beat 15; first out_valid exactly 6 cycles after the last accept; frame_cnt=1.
- Bit-reverse ordering with a stub FFT (output slot n = n): BITREV_OUT=1 -> out_real sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. BITREV_OUT=0 -> sequence 0..15.
- Backpressure: out_ready toggles 1,0,0,1 during DRAIN while the next frame streams in -> no beat lost or duplicated. in_ready drops after the 16th accept. Second frame enters WAIT on the edge of frame 1's out_last handshake; frame_cnt=2.
- Simultaneous events: 16th input accept and out_last handshake on the same edge -> state=WAIT next cycle, wait_cnt=0, in_ready=0.
- flush with in_cnt=9 in LOAD, and separately with out_k=7 in DRAIN -> next cycle out_valid=0, in_ready=1, busy=0, frame_cnt unchanged. A fresh 16-sample frame then produces a correct result.
- Async rst asserted mid-WAIT, between clock edges -> outputs take reset values immediately, with no capture. frame_cnt wrap: preload to 0xFFFF via forced frames, then one more frame -> frame_cnt=0.
